// File: rtl/mem_port_arb.sv
// mem_port_arb: two-way arbiter (IFU fetch vs. LSU load/store) in front of a
// single-ported, fixed-latency memory. One transaction in flight at a time:
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
//
// Optional build macro ARB_LSU_PRIO_EN: when defined, the LSU wins every tie
// (fixed priority); otherwise ties alternate round-robin on last_owner.
//
// Memory timing: mem_en is launched at edge T and the memory must present
// mem_rdata so that it is sampled at edge T+MEM_LAT. lat_cnt holds MEM_LAT-1
// during ISSUE and counts down, so with MEM_LAT = 1 the capture happens at the
// end of ISSUE and WAIT is skipped. rvalid lands in cycle T+1+MEM_LAT.
module mem_port_arb #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          lsu_req,
  input  logic          lsu_we,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

  state_e     state_q;
  logic [3:0] lat_cnt_q;
  logic       owner_q;       // 1 = LSU owns the current transaction
  logic       last_owner_q;  // 1 = LSU completed the previous transaction
  logic       pick_lsu;

  // Winner selection, only acted on in IDLE
  always_comb begin
`ifdef ARB_LSU_PRIO_EN
    pick_lsu = lsu_req;
`else
    pick_lsu = lsu_req && (!if_req || !last_owner_q);
`endif
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q      <= StIdle;
      lat_cnt_q    <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      if_gnt       <= 1'b0;
      if_rvalid    <= 1'b0;
      lsu_gnt      <= 1'b0;
      lsu_rvalid   <= 1'b0;
      rdata        <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      // Pulses default low every cycle
      if_gnt     <= 1'b0;
      lsu_gnt    <= 1'b0;
      if_rvalid  <= 1'b0;
      lsu_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || lsu_req) begin
            owner_q   <= pick_lsu;
            // mem_we/addr/wdata double as the latched request and hold
            // through the transaction
            mem_we    <= pick_lsu & lsu_we;
            mem_addr  <= pick_lsu ? lsu_addr : if_addr;
            mem_wdata <= pick_lsu ? lsu_wdata : '0;
            mem_en    <= 1'b1;
            if_gnt    <= ~pick_lsu;
            lsu_gnt   <= pick_lsu;
            lat_cnt_q <= LatInit;
            busy      <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue, StWait: begin
          if (lat_cnt_q == 4'd0) begin
            // Writes leave rdata untouched; lsu_rvalid is then the ack
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            if_rvalid  <= ~owner_q;
            lsu_rvalid <= owner_q;
            state_q    <= StResp;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
            state_q   <= StWait;
          end
        end
        StResp: begin
          last_owner_q <= owner_q;
          busy         <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: main instance (MEM_LAT = 2) checked by a scoreboard
// fed from directed stimulus; two extra instances (MEM_LAT = 1 and 4) check
// response latency. Memory models only drive real data in the exact cycle the
// arbiter should sample it, so a mistimed capture returns 0xBAD0BAD0.
`timescale 1ns/1ps
module tb_mem_port_arb;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam logic [DW-1:0] Bad = 32'hBAD0BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_f;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;

  mem_port_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Preset contents; anything else reads as {addr, ~addr}
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      16'h0010: rom = 32'hDEADBEEF;
      16'h0040: rom = 32'hCAFEF00D;
      default:  rom = {a, ~a};
    endcase
  endfunction

  // Main memory model: one-entry write overlay plus age counter since mem_en
  logic [3:0]    age;
  logic [AW-1:0] cap_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_vld;
  always @(posedge clk) begin
    if (!rst_f) begin
      age <= '0;
      cap_addr <= '0;
    end else if (mem_en) begin
      age <= 4'd1;
      cap_addr <= mem_addr;
      if (mem_we) begin
        wr_vld  <= 1'b1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
    end else if (age != 4'd0 && age != 4'hf) begin
      age <= age + 4'd1;
    end
  end
  initial wr_vld = 1'b0;
  assign mem_rdata = (age != 4'd0 && age == 4'(LAT - 1)) ?
                     ((wr_vld && wr_addr == cap_addr) ? wr_data : rom(cap_addr)) : Bad;

  // Latency instances: index 0 -> MEM_LAT 1, index 1 -> MEM_LAT 4
  logic          x_req   [2];
  logic [AW-1:0] x_addr  [2];
  logic          x_gnt   [2];
  logic          x_rv    [2];
  logic          x_lgnt  [2];
  logic          x_lrv   [2];
  logic          x_en    [2];
  logic          x_we    [2];
  logic          x_busy  [2];
  logic [AW-1:0] x_maddr [2];
  logic [DW-1:0] x_rdata [2];
  logic [DW-1:0] x_wdata [2];
  logic [DW-1:0] x_mrdata[2];
  logic [AW-1:0] zero_a = '0;
  logic [DW-1:0] zero_d = '0;
  logic          zero_b = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned L = (g == 0) ? 1 : 4;
    logic [3:0]    xage;
    logic [AW-1:0] xcap;
    mem_port_arb #(.AW(AW), .DW(DW), .MEM_LAT(L)) u_x (
      .clk(clk), .rst_f(rst_f),
      .if_req(x_req[g]), .if_addr(x_addr[g]), .if_gnt(x_gnt[g]), .if_rvalid(x_rv[g]),
      .lsu_req(zero_b), .lsu_we(zero_b), .lsu_addr(zero_a), .lsu_wdata(zero_d),
      .lsu_gnt(x_lgnt[g]), .lsu_rvalid(x_lrv[g]), .rdata(x_rdata[g]),
      .mem_en(x_en[g]), .mem_we(x_we[g]), .mem_addr(x_maddr[g]), .mem_wdata(x_wdata[g]),
      .mem_rdata(x_mrdata[g]), .busy(x_busy[g])
    );
    always @(posedge clk) begin
      if (!rst_f) begin
        xage <= '0;
        xcap <= '0;
      end else if (x_en[g]) begin
        xage <= 4'd1;
        xcap <= x_maddr[g];
      end else if (xage != 4'd0 && xage != 4'hf) begin
        xage <= xage + 4'd1;
      end
    end
    if (L == 1) begin : g_l1
      assign x_mrdata[g] = x_en[g] ? rom(x_maddr[g]) : Bad;
    end else begin : g_ln
      assign x_mrdata[g] = (xage == 4'(L - 1)) ? rom(xcap) : Bad;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct packed {
    logic          lsu;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [7:0]    spacing;  // required gnt-to-gnt distance, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   pending = 1'b0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   last_gnt_cyc = -100;

  task automatic push_exp(input logic l, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int sp);
    exp_t e;
    e.lsu = l; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd; e.spacing = 8'(sp);
    exp_q.push_back(e);
  endtask

  // Monitor: pops on every grant, matches the response against it
  always @(negedge clk) begin
    cyc++;
    if (!rst_f) begin
      pending = 1'b0;
      last_gnt_cyc = -100;
    end else begin
      check("pulse exclusivity",
            {60'd0, if_gnt & lsu_gnt, if_rvalid & lsu_rvalid,
             mem_en ^ (if_gnt | lsu_gnt), (if_gnt | lsu_gnt) & (if_rvalid | lsu_rvalid)}, 64'd0);
      if (if_gnt || lsu_gnt) begin
        if (exp_q.size() == 0) begin
          check("unexpected gnt", {62'd0, lsu_gnt, if_gnt}, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          check("gnt owner", lsu_gnt, cur.lsu);
          check("mem_we", mem_we, cur.we);
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wdata", mem_wdata, cur.wdata);
          if (cur.spacing != 0) check("gnt spacing", cyc - last_gnt_cyc, cur.spacing);
          pending = 1'b1;
          gnt_cyc = cyc;
          last_gnt_cyc = cyc;
        end
      end
      if (if_rvalid || lsu_rvalid) begin
        if (!pending) begin
          check("unexpected rvalid", {62'd0, lsu_rvalid, if_rvalid}, 64'd0);
        end else begin
          check("rvalid owner", lsu_rvalid, cur.lsu);
          check("rvalid latency", cyc - gnt_cyc, LAT);
          check("rdata", rdata, cur.rdata);
          pending = 1'b0;
        end
      end
    end
  end

  task automatic wait_gnt(output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (if_gnt || lsu_gnt) got = 1'b1;
    end
    if (!got) check("gnt timeout", 1, 0);
  endtask

  task automatic wait_rv();
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (if_rvalid || lsu_rvalid) got = 1'b1;
    end
    if (!got) check("rvalid timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle timeout", 1, 0);
  endtask

  task automatic ifu_read(input logic [AW-1:0] a);
    int n;
    if_req = 1'b1; if_addr = a;
    wait_gnt(n);
    if_req = 1'b0;
  endtask

  task automatic lsu_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    lsu_req = 1'b1; lsu_we = w; lsu_addr = a; lsu_wdata = d;
    wait_gnt(n);
    lsu_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_f = 1'b0;
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
  endtask

  task automatic lat_test(input int idx, input int exp_lat, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp_d);
    int n = 0;
    bit got = 1'b0;
    @(negedge clk);
    x_req[idx] = 1'b1; x_addr[idx] = a;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (x_gnt[idx]) got = 1'b1;
    end
    x_req[idx] = 1'b0;
    check("lat gnt cycle", n, 1);
    got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (x_rv[idx]) got = 1'b1;
    end
    check("lat rvalid cycle", n, 1 + exp_lat);
    check("lat rdata", x_rdata[idx], exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    rst_f = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    for (int i = 0; i < 2; i++) begin x_req[i] = 1'b0; x_addr[i] = '0; end
    repeat (3) @(negedge clk);
    check("reset ctrl", {if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_en, mem_we, busy}, 0);
    check("reset rdata", rdata, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    rst_f = 1'b1;
    @(negedge clk);
    check("idle after release", {mem_en, busy}, 0);

    // IFU read 0x0010
    push_exp(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);
    if_req = 1'b1; if_addr = 16'h0010;
    wait_gnt(n);
    if_req = 1'b0;
    check("ifu gnt latency", n, 1);
    wait_rv();
    @(negedge clk);
    check("busy falls", busy, 0);

    // LSU write: rdata must keep the previous read value
    push_exp(1'b1, 1'b1, 16'h0020, 32'h12345678, 32'hDEADBEEF, 0);
    lsu_op(1'b1, 16'h0020, 32'h12345678);
    wait_rv();
    wait_idle();

    // LSU read-back of the write
    push_exp(1'b1, 1'b0, 16'h0020, 32'h0, 32'h12345678, 0);
    lsu_op(1'b0, 16'h0020, 32'h0);
    wait_rv();
    wait_idle();

    // Both held after reset
    do_reset();
`ifdef ARB_LSU_PRIO_EN
    push_exp(1'b1, 1'b0, 16'h0040, 32'h0, 32'hCAFEF00D, 0);
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 16'h0040, 32'h0, 32'hCAFEF00D, LAT + 2);
`else
    push_exp(1'b1, 1'b0, 16'h0040, 32'h0, 32'hCAFEF00D, 0);
    push_exp(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, LAT + 2);
    push_exp(1'b1, 1'b0, 16'h0040, 32'h0, 32'hCAFEF00D, LAT + 2);
    push_exp(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, LAT + 2);
`endif
    if_req = 1'b1; if_addr = 16'h0010;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 16'h0040; lsu_wdata = 32'h0;
    k = 0; n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (if_gnt || lsu_gnt) k++;
    end
    if_req = 1'b0; lsu_req = 1'b0;
    check("contended grants", k, 4);
    wait_idle();

    // Reset during WAIT of an IFU read: that read never responds
    push_exp(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);
    ifu_read(16'h0010);
    @(posedge clk);
    #1 rst_f = 1'b0;
    #1;
    check("abort ctrl", {if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_en, mem_we, busy}, 0);
    check("abort rdata", rdata, 0);
    check("abort mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
    repeat (4) @(negedge clk);
    push_exp(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);
    ifu_read(16'h0010);
    wait_rv();
    wait_idle();

    // One-cycle LSU request while busy: must vanish
    push_exp(1'b0, 1'b0, 16'h0040, 32'h0, 32'hCAFEF00D, 0);
    ifu_read(16'h0040);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 16'h0020;
    @(negedge clk);
    lsu_req = 1'b0;
    wait_rv();
    wait_idle();
    repeat (4) @(negedge clk);

    // Latency at MEM_LAT 1 and 4
    lat_test(0, 1, 16'h0010, 32'hDEADBEEF);
    lat_test(1, 4, 16'h0123, 32'h0123FEDC);

    repeat (2) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    check("no response outstanding", {63'd0, pending}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
